// File: rtl/ikaopll_lfo_pkg.sv
// Shared IKAOPLL LFO constants and types.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ikaopll_lfo_pkg;

  localparam int         LFO_PM_PRESC_BITS = 10;
  localparam int         LFO_AM_PRESC_BITS = 6;
  localparam logic [6:0] LFO_AM_TOP        = 7'd105;

  // Direction of the AM triangle counter.
  typedef enum logic {
    LFO_UP   = 1'b0,
    LFO_DOWN = 1'b1
  } lfo_dir_t;

endpackage

// File: rtl/ikaopll_lfo_if.sv
// Timing/test inputs and vibrato/tremolo outputs of the LFO stage.
// Latency: n/a (wiring only).
// Backpressure: none; the clock enable is the only pacing signal.
interface ikaopll_lfo_if;

  logic       i_phi1_NCEN_n;
  logic       i_CYCLE_00;
  logic [3:0] i_TEST;
  logic [2:0] o_PMVAL;
  logic [3:0] o_AMVAL;

  // Timing generator / test bench side.
  modport master (
    output i_phi1_NCEN_n,
    output i_CYCLE_00,
    output i_TEST,
    input  o_PMVAL,
    input  o_AMVAL
  );

  // LFO side.
  modport slave (
    input  i_phi1_NCEN_n,
    input  i_CYCLE_00,
    input  i_TEST,
    output o_PMVAL,
    output o_AMVAL
  );

endinterface

// File: rtl/ikaopll_lfo_prescaler.sv
// Free-running WIDTH-bit tick prescaler emitting a wrap pulse on its all-ones tick.
// Latency: wrap_o is combinational from tick_i and the registered count.
// Backpressure: none; the count only moves on tick_i.
module ikaopll_lfo_prescaler #(
  parameter int WIDTH = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic tick_i,
  output logic wrap_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: clear wins over tick, count wraps naturally at its width.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Wrap fires on the tick that takes the count from all-ones back to zero.
  assign wrap_o = tick_i & ~clr_i & (&cnt_q);

endmodule

// File: rtl/ikaopll_lfo.sv
// LFO: PM sawtooth-index counter (vibrato) and AM triangle counter (tremolo).
// Latency: outputs registered; they move on the enabled edge carrying a prescaler wrap.
// Backpressure: none; all state holds while i_phi1_NCEN_n is high.
module ikaopll_lfo
  import ikaopll_lfo_pkg::*;
#(
  parameter int         PM_PRESC_BITS = LFO_PM_PRESC_BITS,
  parameter int         AM_PRESC_BITS = LFO_AM_PRESC_BITS,
  parameter logic [6:0] AM_TOP        = LFO_AM_TOP
) (
  input  logic          i_EMUCLK,
  input  logic          i_IC,
  ikaopll_lfo_if.slave  bus
);

  logic     enabled;
  logic     step_tick;
  logic     lfo_clr;
  logic     presc_tick;
  logic     pm_wrap;
  logic     am_wrap;
  logic     unused_test;

  logic [2:0] pm_cnt_q, pm_cnt_d;
  logic [6:0] am_cnt_q, am_cnt_d;
  lfo_dir_t   am_dir_q, am_dir_d;

  // TEST[3] turns every enabled slot into a step; TEST[1] holds everything cleared.
  assign enabled     = ~bus.i_phi1_NCEN_n;
  assign step_tick   = enabled & (bus.i_CYCLE_00 | bus.i_TEST[3]);
  assign lfo_clr     = enabled & bus.i_TEST[1];
  assign presc_tick  = step_tick & ~lfo_clr;
  assign unused_test = bus.i_TEST[2] ^ bus.i_TEST[0];

  ikaopll_lfo_prescaler #(.WIDTH(PM_PRESC_BITS)) u_pm_presc (
    .clk_i  (i_EMUCLK),
    .rst_i  (i_IC),
    .clr_i  (lfo_clr),
    .tick_i (presc_tick),
    .wrap_o (pm_wrap)
  );

  ikaopll_lfo_prescaler #(.WIDTH(AM_PRESC_BITS)) u_am_presc (
    .clk_i  (i_EMUCLK),
    .rst_i  (i_IC),
    .clr_i  (lfo_clr),
    .tick_i (presc_tick),
    .wrap_o (am_wrap)
  );

  // PM index: plain modulo-8 step on every PM prescaler wrap.
  always_comb begin
    pm_cnt_d = pm_cnt_q;
    if (lfo_clr) begin
      pm_cnt_d = 3'd0;
    end else if (pm_wrap) begin
      pm_cnt_d = pm_cnt_q + 3'd1;
    end
  end

  // AM triangle: turn around on reaching either end so each end value lasts one step.
  always_comb begin
    am_cnt_d = am_cnt_q;
    am_dir_d = am_dir_q;
    if (lfo_clr) begin
      am_cnt_d = 7'd0;
      am_dir_d = LFO_UP;
    end else if (am_wrap) begin
      if (am_dir_q == LFO_UP) begin
        am_cnt_d = am_cnt_q + 7'd1;
        if (am_cnt_d == AM_TOP) begin
          am_dir_d = LFO_DOWN;
        end
      end else begin
        am_cnt_d = am_cnt_q - 7'd1;
        if (am_cnt_d == 7'd0) begin
          am_dir_d = LFO_UP;
        end
      end
    end
  end

  // Counter/direction registers; reset overrides every other condition.
  always_ff @(posedge i_EMUCLK) begin
    if (i_IC) begin
      pm_cnt_q <= 3'd0;
      am_cnt_q <= 7'd0;
      am_dir_q <= LFO_UP;
    end else begin
      pm_cnt_q <= pm_cnt_d;
      am_cnt_q <= am_cnt_d;
      am_dir_q <= am_dir_d;
    end
  end

  assign bus.o_PMVAL = pm_cnt_q;
  assign bus.o_AMVAL = am_cnt_q[6:3];

endmodule

// File: tb/tb_ikaopll_lfo.sv
// Scoreboard bench for ikaopll_lfo: driver pushes expected outputs, monitor compares.
// Latency: expectation for a driven cycle is checked 1 time unit after its posedge.
// Backpressure: none.
module tb_ikaopll_lfo;
    import ikaopll_lfo_pkg::*;

    logic clk = 1'b0;
    logic ic  = 1'b1;

    ikaopll_lfo_if bus ();

    ikaopll_lfo dut (
        .i_EMUCLK (clk),
        .i_IC     (ic),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string nm;
        int    pm;
        int    am;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   n      = 0;

    function automatic int model_pm(input int t);
        return (t >> LFO_PM_PRESC_BITS) % 8;
    endfunction

    function automatic int model_am(input int t);
        int s;
        int top;
        top = int'(LFO_AM_TOP);
        s   = (t >> LFO_AM_PRESC_BITS) % (2 * top);
        return ((s <= top) ? s : (2 * top - s)) >> 3;
    endfunction

    task automatic step(input logic ncen, input logic c00, input logic rst,
                        input logic [3:0] test, input bit dchk = 1'b0,
                        input string nm = "", input int dpm = 0, input int dam = 0);
        exp_t e;
        @(negedge clk);
        bus.i_phi1_NCEN_n = ncen;
        bus.i_CYCLE_00    = c00;
        bus.i_TEST        = test;
        ic                = rst;
        if (rst) n = 0;
        else if (!ncen) begin
            if (test[1]) n = 0;
            else if (c00 | test[3]) n++;
        end
        if (dchk) begin
            e.nm = nm; e.pm = dpm; e.am = dam;
        end else begin
            e.nm = "model"; e.pm = model_pm(n); e.am = model_am(n);
        end
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (bus.o_PMVAL !== 3'(mon_e.pm) || bus.o_AMVAL !== 4'(mon_e.am)) begin
                errors++;
                $display("FAIL %s: got pm=%0d am=%0d, expected pm=%0d am=%0d",
                         mon_e.nm, bus.o_PMVAL, bus.o_AMVAL, mon_e.pm, mon_e.am);
            end
        end
    end

    int ck_t [13] = '{64, 511, 512, 1023, 1024, 2048, 6720, 6783, 6784, 8191, 8192, 13440, 13952};
    int ck_pm[13] = '{ 0,   0,   0,    0,    1,    2,    6,    6,    6,    7,    0,     5,     5};
    int ck_am[13] = '{ 0,   0,   1,    1,    2,    4,   13,   13,   13,   10,   10,     0,     1};

    initial begin
        int k;
        int slot;
        logic ncen;
        bus.i_phi1_NCEN_n = 1'b1;
        bus.i_CYCLE_00    = 1'b0;
        bus.i_TEST        = 4'd0;

        step(1'b1, 1'b0, 1'b1, 4'd0, 1'b1, "reset_dis", 0, 0);
        step(1'b0, 1'b1, 1'b1, 4'd0, 1'b1, "reset_en", 0, 0);

        k = 0;
        for (int t = 1; t <= 13952; t++) begin
            if (k < 13 && t == ck_t[k]) begin
                step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, $sformatf("norm_t%0d", t), ck_pm[k], ck_am[k]);
                k++;
            end else begin
                step(1'b0, 1'b1, 1'b0, 4'd0);
            end
        end

        step(1'b0, 1'b0, 1'b1, 4'd0);
        for (int t = 1; t <= 1000; t++) step(1'b0, 1'b0, 1'b0, 4'b1000);
        for (int i = 0; i < 100; i++) step(1'b1, i[0], 1'b0, 4'b1000);
        step(1'b1, 1'b1, 1'b0, 4'b1000, 1'b1, "gap_hold", 0, 1);
        for (int t = 1001; t <= 1022; t++) step(1'b0, 1'b0, 1'b0, 4'b1000);
        step(1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, "fast_1023", 0, 1);
        step(1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, "fast_1024", 1, 2);
        for (int t = 1025; t < 2100; t++) step(1'b0, 1'b0, 1'b0, 4'b1000);
        step(1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, "fast_2100", 2, 4);

        step(1'b0, 1'b1, 1'b0, 4'b1010, 1'b1, "clear", 0, 0);
        step(1'b0, 1'b1, 1'b0, 4'b1010);
        step(1'b1, 1'b1, 1'b0, 4'b1010);
        step(1'b0, 1'b0, 1'b0, 4'b1010);
        for (int t = 1; t <= 1022; t++) step(1'b0, 1'b0, 1'b0, 4'b1000);
        step(1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, "clr_resume_1023", 0, 1);
        step(1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, "clr_resume_1024", 1, 2);

        step(1'b0, 1'b0, 1'b1, 4'd0);
        for (int t = 1; t < 21887; t++) step(1'b0, 1'b0, 1'b0, 4'b1000);
        step(1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, "pre_rst", 5, 9);
        step(1'b0, 1'b1, 1'b1, 4'b1000, 1'b1, "rst_prio", 0, 0);
        @(posedge clk);
        #2;
        checks++;
        if (bus.o_PMVAL !== 3'd0 || bus.o_AMVAL !== 4'd0) begin
            errors++;
            $display("FAIL rst_prio_direct: got pm=%0d am=%0d", bus.o_PMVAL, bus.o_AMVAL);
        end
        for (int t = 1; t <= 1024; t++) begin
            if (t == 64)        step(1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, "post_rst_64", 0, 0);
            else if (t == 1024) step(1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, "post_rst_1024", 1, 2);
            else                step(1'b0, 1'b0, 1'b0, 4'b1000);
        end

        step(1'b0, 1'b0, 1'b1, 4'd0);
        for (int s = 0; s < 1500; s++) begin
            slot = 0;
            while (slot < 18) begin
                ncen = ($urandom_range(0, 3) == 0);
                step(ncen, (slot == 0), 1'b0, 4'd0);
                if (!ncen) slot++;
            end
        end

        @(posedge clk);
        #2;
        if (checks < 12) begin
            errors++;
            $display("FAIL too few checks executed: %0d", checks);
        end
        if (errors != 0) begin
            $display("FAIL summary: %0d errors", errors);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: run did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
